// File: rtl/md_pkg.sv
// Shared MD datapath types: force tuples, particle/cell ids and the writeback record.
// Widths are kept modest so the writeback record fits in one bus beat.
package md_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int CELL_COORD_WIDTH  = 3;
    localparam int PARTICLE_ID_WIDTH = 8;

    typedef struct packed {
        logic [CELL_COORD_WIDTH-1:0] x;
        logic [CELL_COORD_WIDTH-1:0] y;
        logic [CELL_COORD_WIDTH-1:0] z;
    } full_cell_id_t;

    typedef struct packed {
        full_cell_id_t                cell_id;
        logic [PARTICLE_ID_WIDTH-1:0] particle_id;
    } full_id_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] z;
        logic [DATA_WIDTH-1:0] y;
        logic [DATA_WIDTH-1:0] x;
    } data_tuple_t;

    typedef struct packed {
        full_id_t              id;
        logic [DATA_WIDTH-1:0] z;
        logic [DATA_WIDTH-1:0] y;
        logic [DATA_WIDTH-1:0] x;
    } force_wb_t;

endpackage

// File: rtl/force_wb_distributor_fifo.sv
// Neighbor-force FIFO (power-of-2 depth); a push into a full FIFO succeeds only with a same-cycle pop.
module nb_force_fifo
    import md_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  force_wb_t data_i,
    input  logic      pop_i,
    output force_wb_t data_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    force_wb_t   mem_q [DEPTH];
    logic        do_push, do_pop;

    // The extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop   = pop_i && !empty_o;
    assign do_push  = push_i && (!full_o || do_pop);
    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign data_o   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/force_wb_distributor.sv
// Streams neighbor forces to the writeback bus and, on request, drains the per-phase reference slots.
// Reference writeback starts only after WAIT_CYCLES consecutive cycles with no neighbor traffic.
module force_wb_distributor
    import md_pkg::*;
#(
    parameter int NUM_FILTER    = 7,
    parameter int NUM_PHASES    = 2,
    parameter int WAIT_CYCLES   = 5,
    parameter int NB_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_wb,
    input  data_tuple_t           ref_force       [NUM_FILTER],
    input  full_id_t              ref_id          [NUM_FILTER],
    input  logic [NUM_FILTER-1:0] ref_force_valid,
    input  full_cell_id_t         phase_cell_id   [NUM_PHASES][NUM_FILTER],
    input  data_tuple_t           force_in,
    input  full_id_t              nb_id,
    input  logic                  force_valid,
    input  logic                  ready,
    output force_wb_t             wb_out,
    output logic                  wb_valid,
    output logic                  all_ref_wb_issued,
    output logic                  err_nb_overflow,
    output logic                  err_ref_lost,
    output logic                  err_no_phase
);
    localparam int NUM_SLOTS = NUM_FILTER * NUM_PHASES;
    localparam int CNT_W     = $clog2(WAIT_CYCLES + 1);
    localparam int PTR_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [1:0] {ST_ACTIVE, ST_WAIT, ST_WB_REF} wb_state_e;

    wb_state_e            state_q, state_d;
    logic [CNT_W-1:0]     quiet_cnt_q, quiet_cnt_d;
    logic [PTR_W-1:0]     slot_ptr_q, slot_ptr_d;
    logic [NUM_SLOTS-1:0] slot_vld_q, slot_vld_d;
    force_wb_t            slot_q [NUM_SLOTS];
    logic                 pulse_q, pulse_d;
    logic                 err_nb_q, err_nb_d;
    logic                 err_lost_q, err_lost_d;
    logic                 err_phase_q, err_phase_d;

    logic [NUM_SLOTS-1:0] slot_we;
    logic                 miss_any;
    logic                 capture_en, quiet, slot_last, slot_advance, ref_done, fifo_pop;
    logic                 fifo_full, fifo_empty;
    force_wb_t            fifo_head, nb_entry;

    assign nb_entry  = '{id: nb_id, z: force_in.z, y: force_in.y, x: force_in.x};
    assign quiet     = !force_valid && fifo_empty;
    assign slot_last = (slot_ptr_q == PTR_W'(NUM_SLOTS - 1));

    nb_force_fifo #(
        .DEPTH (NB_FIFO_DEPTH)
    ) u_nb_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (force_valid),
        .data_i  (nb_entry),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Each channel lands in the slot of the lowest phase whose cell id matches.
    always_comb begin
        slot_we  = '0;
        miss_any = 1'b0;
        for (int i = 0; i < NUM_FILTER; i++) begin : chan_scan
            logic hit;
            hit = 1'b0;
            for (int p = 0; p < NUM_PHASES; p++) begin
                if (capture_en && ref_force_valid[i] && !hit &&
                    ref_id[i].cell_id == phase_cell_id[p][i]) begin
                    slot_we[p*NUM_FILTER + i] = 1'b1;
                    hit = 1'b1;
                end
            end
            if (capture_en && ref_force_valid[i] && !hit) miss_any = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_ACTIVE;
        else        state_q <= state_d;
    end

    // A start request landing on the completion-pulse cycle is deliberately dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: if (start_wb && !pulse_q) state_d = ST_WAIT;
            ST_WAIT:   if (quiet && quiet_cnt_q == CNT_W'(WAIT_CYCLES - 1)) state_d = ST_WB_REF;
            ST_WB_REF: if (ref_done) state_d = ST_ACTIVE;
            default:   state_d = ST_ACTIVE;
        endcase
    end

    // During reference writeback the FIFO is held back so slots own the bus.
    always_comb begin
        capture_en   = 1'b1;
        slot_advance = 1'b0;
        ref_done     = 1'b0;
        fifo_pop     = 1'b0;
        wb_valid     = !fifo_empty;
        wb_out       = fifo_head;
        case (state_q)
            ST_WB_REF: begin
                capture_en   = 1'b0;
                wb_valid     = slot_vld_q[slot_ptr_q];
                wb_out       = slot_q[slot_ptr_q];
                slot_advance = !slot_vld_q[slot_ptr_q] || ready;
                ref_done     = slot_advance && slot_last;
            end
            default: fifo_pop = !fifo_empty && ready;
        endcase
    end

    always_comb begin
        quiet_cnt_d = quiet_cnt_q;
        slot_ptr_d  = slot_ptr_q;
        slot_vld_d  = slot_vld_q | slot_we;
        pulse_d     = ref_done;
        err_nb_d    = err_nb_q | (force_valid && fifo_full && !fifo_pop);
        err_lost_d  = err_lost_q | ((state_q == ST_WB_REF) && (|ref_force_valid));
        err_phase_d = err_phase_q | miss_any;
        if (state_q == ST_ACTIVE && state_d == ST_WAIT) begin
            quiet_cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            quiet_cnt_d = quiet ? quiet_cnt_q + 1'b1 : '0;
        end
        if (state_q == ST_WAIT && state_d == ST_WB_REF) begin
            slot_ptr_d = '0;
        end else if (slot_advance) begin
            slot_ptr_d = slot_last ? '0 : slot_ptr_q + 1'b1;
        end
        if (ref_done) slot_vld_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quiet_cnt_q <= '0;
            slot_ptr_q  <= '0;
            slot_vld_q  <= '0;
            pulse_q     <= 1'b0;
            err_nb_q    <= 1'b0;
            err_lost_q  <= 1'b0;
            err_phase_q <= 1'b0;
        end else begin
            quiet_cnt_q <= quiet_cnt_d;
            slot_ptr_q  <= slot_ptr_d;
            slot_vld_q  <= slot_vld_d;
            pulse_q     <= pulse_d;
            err_nb_q    <= err_nb_d;
            err_lost_q  <= err_lost_d;
            err_phase_q <= err_phase_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (slot_we[s]) begin
                slot_q[s] <= '{id: ref_id[s % NUM_FILTER],
                               z:  ref_force[s % NUM_FILTER].z,
                               y:  ref_force[s % NUM_FILTER].y,
                               x:  ref_force[s % NUM_FILTER].x};
            end
        end
    end

    assign all_ref_wb_issued = pulse_q;
    assign err_nb_overflow   = err_nb_q;
    assign err_ref_lost      = err_lost_q;
    assign err_no_phase      = err_phase_q;

endmodule

// File: tb/tb_force_wb_distributor.sv
// Directed and randomized checks of force_wb_distributor against a queue/array reference model.
module tb_force_wb_distributor;
    import md_pkg::*;

    localparam int NF    = 7;
    localparam int NP    = 2;
    localparam int WAITC = 5;
    localparam int DEPTH = 4;
    localparam int NS    = NF * NP;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_wb;
    data_tuple_t   ref_force [NF];
    full_id_t      ref_id [NF];
    logic [NF-1:0] ref_force_valid;
    full_cell_id_t phase_cell_id [NP][NF];
    data_tuple_t   force_in;
    full_id_t      nb_id;
    logic          force_valid;
    logic          ready;
    force_wb_t     wb_out;
    logic          wb_valid;
    logic          all_ref_wb_issued;
    logic          err_nb_overflow;
    logic          err_ref_lost;
    logic          err_no_phase;

    always #5 clk = ~clk;

    force_wb_distributor #(
        .NUM_FILTER    (NF),
        .NUM_PHASES    (NP),
        .WAIT_CYCLES   (WAITC),
        .NB_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_wb          (start_wb),
        .ref_force         (ref_force),
        .ref_id            (ref_id),
        .ref_force_valid   (ref_force_valid),
        .phase_cell_id     (phase_cell_id),
        .force_in          (force_in),
        .nb_id             (nb_id),
        .force_valid       (force_valid),
        .ready             (ready),
        .wb_out            (wb_out),
        .wb_valid          (wb_valid),
        .all_ref_wb_issued (all_ref_wb_issued),
        .err_nb_overflow   (err_nb_overflow),
        .err_ref_lost      (err_ref_lost),
        .err_no_phase      (err_no_phase)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 waiting for quiet, 2 writing back slots.
    int        mMode, mQuiet, mPtr;
    bit        mPulse, mErrNb, mErrLost, mErrPhase;
    bit        mSlotV [NS];
    force_wb_t mSlot [NS];
    force_wb_t mQ[$];
    force_wb_t sent[$];

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic full_cell_id_t cellOf(input int p, input int i);
        full_cell_id_t c;
        c.x = (i == NF - 1) ? 3'd1 : 3'(p + 1);
        c.y = 3'(i);
        c.z = 3'd2;
        return c;
    endfunction

    function automatic bit expValid();
        if (mMode == 2) return mSlotV[mPtr];
        return mQ.size() > 0;
    endfunction

    function automatic force_wb_t expOut();
        if (mMode == 2) return mSlot[mPtr];
        return mQ[0];
    endfunction

    task automatic modelReset();
        mMode = 0; mQuiet = 0; mPtr = 0;
        mPulse = 0; mErrNb = 0; mErrLost = 0; mErrPhase = 0;
        foreach (mSlotV[s]) mSlotV[s] = 0;
        mQ.delete();
    endtask

    task automatic modelStep();
        bit xfer, wasEmpty, pulseNext;
        force_wb_t e;
        xfer      = expValid() && ready;
        wasEmpty  = (mQ.size() == 0);
        pulseNext = 0;
        if (xfer) sent.push_back(expOut());
        if (mMode != 2) begin
            for (int i = 0; i < NF; i++) begin
                if (ref_force_valid[i]) begin
                    int hitP;
                    hitP = -1;
                    for (int p = NP - 1; p >= 0; p--)
                        if (ref_id[i].cell_id == phase_cell_id[p][i]) hitP = p;
                    if (hitP < 0) mErrPhase = 1;
                    else begin
                        mSlot[hitP*NF + i]  = '{id: ref_id[i], z: ref_force[i].z, y: ref_force[i].y, x: ref_force[i].x};
                        mSlotV[hitP*NF + i] = 1;
                    end
                end
            end
        end else if (ref_force_valid != '0) begin
            mErrLost = 1;
        end
        if (xfer && mMode != 2) e = mQ.pop_front();
        if (force_valid) begin
            if (mQ.size() < DEPTH) mQ.push_back('{id: nb_id, z: force_in.z, y: force_in.y, x: force_in.x});
            else mErrNb = 1;
        end
        case (mMode)
            0: if (start_wb && !mPulse) begin mMode = 1; mQuiet = 0; end
            1: begin
                if (force_valid || !wasEmpty) mQuiet = 0;
                else mQuiet++;
                if (mQuiet == WAITC) begin mMode = 2; mPtr = 0; end
            end
            default: if (!mSlotV[mPtr] || ready) begin
                if (mPtr == NS - 1) begin
                    foreach (mSlotV[s]) mSlotV[s] = 0;
                    pulseNext = 1;
                    mMode = 0;
                end else mPtr++;
            end
        endcase
        mPulse = pulseNext;
    endtask

    task automatic checkAll();
        bit ev;
        ev = expValid();
        checkOutput("wb_valid", 128'(wb_valid), 128'(ev));
        if (ev) checkOutput("wb_out", 128'(wb_out), 128'(expOut()));
        checkOutput("all_ref_wb_issued", 128'(all_ref_wb_issued), 128'(mPulse));
        checkOutput("err_nb_overflow", 128'(err_nb_overflow), 128'(mErrNb));
        checkOutput("err_ref_lost", 128'(err_ref_lost), 128'(mErrLost));
        checkOutput("err_no_phase", 128'(err_no_phase), 128'(mErrPhase));
    endtask

    // Called just after a falling edge with inputs already set for the coming rising edge.
    task automatic applyStimulus();
        checkAll();
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clearInputs();
        start_wb        = 1'b0;
        force_valid     = 1'b0;
        ref_force_valid = '0;
        ready           = 1'b1;
    endtask

    task automatic loadRef(input int i, input int p, input bit bogus);
        ref_force_valid[i] = 1'b1;
        ref_id[i].cell_id  = cellOf(p, i);
        if (bogus) ref_id[i].cell_id.x = 3'd7;
        ref_id[i].particle_id = 8'(i);
        ref_force[i] = '{z: $urandom, y: $urandom, x: $urandom};
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc, pulses, stall;
        bit sawValid, reached;
        rst_n = 1'b0;
        clearInputs();
        force_in = '0;
        nb_id    = '0;
        for (int p = 0; p < NP; p++)
            for (int i = 0; i < NF; i++) phase_cell_id[p][i] = cellOf(p, i);
        for (int i = 0; i < NF; i++) begin ref_force[i] = '0; ref_id[i] = '0; end
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_wb_valid", 128'(wb_valid), 128'(0));
        checkOutput("reset_pulse", 128'(all_ref_wb_issued), 128'(0));
        rst_n = 1'b1;
        repeat (2) applyStimulus();

        $display("[TB] seven references, channel 3 in phase 1");
        sent.delete();
        for (int i = 0; i < NF; i++) loadRef(i, (i == 3) ? 1 : 0, 1'b0);
        applyStimulus();
        clearInputs();
        start_wb = 1'b1;
        applyStimulus();
        start_wb = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (all_ref_wb_issued) pulses++;
            applyStimulus();
        end
        checkOutput("ref_pulses", 128'(pulses), 128'(1));
        checkOutput("ref_count", 128'(sent.size()), 128'(7));
        checkOutput("ref_first_pid", 128'(sent[0].id.particle_id), 128'(0));
        checkOutput("ref_last_pid", 128'(sent[sent.size()-1].id.particle_id), 128'(3));
        checkOutput("ref_last_cell", 128'(sent[sent.size()-1].id.cell_id), 128'(cellOf(1, 3)));

        $display("[TB] stall at slot 2");
        sent.delete();
        loadRef(1, 0, 1'b0); loadRef(2, 0, 1'b0); loadRef(4, 0, 1'b0);
        applyStimulus();
        clearInputs();
        start_wb = 1'b1;
        applyStimulus();
        start_wb = 1'b0;
        stall = 0;
        for (int c = 0; c < 40; c++) begin
            ready = 1'b1;
            if (mMode == 2 && mPtr == 2 && stall < 3) begin
                ready = 1'b0;
                checkOutput("stall_hold", 128'(wb_out), 128'(mSlot[2]));
                stall++;
            end
            applyStimulus();
        end
        checkOutput("stall_count", 128'(sent.size()), 128'(3));
        checkOutput("stall_seen", 128'(stall), 128'(3));

        $display("[TB] empty writeback latency");
        sent.delete();
        clearInputs();
        start_wb = 1'b1;
        applyStimulus();
        start_wb = 1'b0;
        cyc = 1;
        sawValid = 0;
        while (!all_ref_wb_issued && cyc < 60) begin
            if (wb_valid) sawValid = 1;
            applyStimulus();
            cyc++;
        end
        checkOutput("pulse_latency", 128'(cyc), 128'(WAITC + 1 + NS));
        checkOutput("empty_wb_valid", 128'(sawValid), 128'(0));

        $display("[TB] neighbor overflow");
        applyStimulus();
        sent.delete();
        ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            force_valid = 1'b1;
            nb_id = '{cell_id: '0, particle_id: 8'(k)};
            force_in = '{z: $urandom, y: $urandom, x: $urandom};
            applyStimulus();
        end
        clearInputs();
        repeat (8) applyStimulus();
        checkOutput("ovf_count", 128'(sent.size()), 128'(4));
        checkOutput("ovf_first", 128'(sent[0].id.particle_id), 128'(1));
        checkOutput("ovf_last", 128'(sent[sent.size()-1].id.particle_id), 128'(4));
        checkOutput("ovf_flag", 128'(err_nb_overflow), 128'(1));

        $display("[TB] reset during reference writeback");
        loadRef(5, 0, 1'b0);
        applyStimulus();
        clearInputs();
        ready = 1'b0;
        start_wb = 1'b1;
        applyStimulus();
        start_wb = 1'b0;
        reached = 0;
        for (int c = 0; c < 40 && !reached; c++) begin
            if (mMode == 2 && mPtr == 5) reached = 1;
            else applyStimulus();
        end
        checkOutput("reach_slot5", 128'(reached), 128'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("rst_wb_valid", 128'(wb_valid), 128'(0));
        checkOutput("rst_pulse", 128'(all_ref_wb_issued), 128'(0));
        checkOutput("rst_err_nb", 128'(err_nb_overflow), 128'(0));
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        clearInputs();
        sent.delete();
        start_wb = 1'b1;
        applyStimulus();
        start_wb = 1'b0;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            if (all_ref_wb_issued) pulses++;
            applyStimulus();
        end
        checkOutput("post_rst_sent", 128'(sent.size()), 128'(0));
        checkOutput("post_rst_pulse", 128'(pulses), 128'(1));

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            start_wb    = ($urandom_range(0, 19) == 0);
            force_valid = ($urandom_range(0, 5) == 0);
            ready       = ($urandom_range(0, 2) != 0);
            nb_id       = '{cell_id: full_cell_id_t'($urandom), particle_id: 8'($urandom)};
            force_in    = '{z: $urandom, y: $urandom, x: $urandom};
            ref_force_valid = '0;
            for (int i = 0; i < NF; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    int sel;
                    sel = $urandom_range(0, 2);
                    loadRef(i, (sel == 1) ? 1 : 0, sel == 2);
                end
            end
            applyStimulus();
        end
        clearInputs();
        repeat (4) applyStimulus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
